fpga_rst_seq: RTL
=================

// Module: fpga_rst_seq
// PURPOSE
//  - Reset/bring-up sequencer sitting directly downstream of the top-level PLL, clocked by its 200MHz output.
//  - Holds IDELAYCTRL in reset for a minimum pulse after PLL lock, waits for its RDY.
//  - Then releases NUM_DOM core reset domains one by one at fixed spacing.
//  - Re-sequences on loss of lock or loss of RDY; counts re-sequence events for debug.
// PARAMETERS
//  NUM_DOM      4     number of sequenced reset domains (1..16)
//  DLY_RST_CYC  16    IDELAYCTRL reset pulse width, clk cycles (>=12 at 200MHz)
//  STEP_CYC     64    spacing between successive domain releases, clk cycles (>=1)
//  WDOG_CYC     4096  RDY watchdog timeout, clk cycles (used only with RST_SEQ_WDOG_EN)
//  SYNC_STAGES  2     flop stages on each async input (>=2)
// PORTS
//  clk       in   1        200MHz sequencer clock (PLL output, BUFG'd)
//  arst_n    in   1        asynchronous active-low reset
//  pll_lock  in   1        raw PLL LOCKED, async; synchronized internally
//  dly_rdy   in   1        IDELAYCTRL RDY, async; synchronized internally
//  dly_rst   out  1        IDELAYCTRL RST, active-high
//  rst_out   out  NUM_DOM  per-domain resets, active-high; bit 0 released first
//  seq_done  out  1        all domains released and stable
//  err_cnt   out  8        re-sequence count, saturating at 8'hFF
// BEHAVIOUR
//  - Reset (arst_n=0, async): dly_rst=1, rst_out='1, seq_done=0, err_cnt=0, state=S_HOLD, counters=0.
//  - All outputs registered; lock_s/rdy_s = SYNC_STAGES-synchronized inputs.
//  - S_HOLD: dly_rst=1, rst_out='1. lock_s=1 -> S_DLY_RST next edge.
//  - S_DLY_RST: dly_rst=1 for exactly DLY_RST_CYC cycles.
//    On expiry -> S_DLY_WAIT; dly_rst falls on that edge.
//  - S_DLY_WAIT: rdy_s=1 -> S_RELEASE; rst_out[0] falls on that edge; step counter cleared.
//  - S_RELEASE: rst_out[k] falls exactly STEP_CYC cycles after rst_out[k-1].
//    After rst_out[NUM_DOM-1] falls -> S_DONE; seq_done rises 1 cycle later.
//  - S_DONE: hold; seq_done=1.
//  - Lock loss (lock_s=0 in any state but S_HOLD):
//    next edge rst_out='1, dly_rst=1, seq_done=0 -> S_HOLD; err_cnt unchanged.
//  - RDY loss (rdy_s=0 in S_RELEASE/S_DONE):
//    next edge rst_out='1, dly_rst=1, seq_done=0 -> S_DLY_RST; err_cnt+1.
//  - Priority on same cycle: arst_n > lock loss > RDY loss/watchdog > normal advance.
//  - err_cnt saturates at 255, never wraps; cleared only by arst_n.
//  - Released domain never re-asserts alone: any abort re-asserts all bits together.
//  - Counters sized $clog2(max(DLY_RST_CYC,STEP_CYC,WDOG_CYC)+1); no wrap in any state.
// CONFIGURATION
//  - RST_SEQ_WDOG_EN defined: counter runs in S_DLY_WAIT.
//    WDOG_CYC cycles without rdy_s -> S_DLY_RST (fresh dly_rst pulse), err_cnt+1.
//  - RST_SEQ_WDOG_EN undefined: S_DLY_WAIT waits indefinitely; no watchdog logic;
//    err_cnt counts RDY-loss events only.
// STRUCTURE
//  - fpga_rst_pkg: state enum rst_seq_state_t {S_HOLD,S_DLY_RST,S_DLY_WAIT,S_RELEASE,S_DONE};
//    ERR_CNT_W=8 constant.
//  - Sub-module fpga_sync_bit (SYNC_STAGES-deep, async-reset-to-0 synchronizer);
//    instantiated for pll_lock and dly_rdy.
// TESTING (NUM_DOM=4, DLY_RST_CYC=16, STEP_CYC=64, WDOG_CYC=4096, SYNC_STAGES=2)
//  - Nominal: arst_n 0->1, pll_lock=1, dly_rdy=1 -> dly_rst high 16 cycles in S_DLY_RST;
//    rst_out 4'hF->E->C->8->0 at 64-cycle spacing; seq_done 1 cycle after last release; err_cnt=0.
//  - Lock loss in S_DONE: pll_lock->0 -> within 3 cycles rst_out=4'hF, dly_rst=1, seq_done=0;
//    relock -> full sequence repeats, err_cnt=0.
//  - RDY loss after rst_out=4'hC -> rst_out=4'hF, dly_rst=1 for 16 cycles, err_cnt=1;
//    RDY back -> re-release.
//  - dly_rdy stuck 0 with RST_SEQ_WDOG_EN -> dly_rst re-pulses each timeout, err_cnt=3 after 3 timeouts;
//    without macro -> stays in S_DLY_WAIT, err_cnt=0.
//  - arst_n asserted mid S_RELEASE -> all outputs to reset values with no clk edge.
//  - Saturation: 300 RDY-loss events -> err_cnt=8'hFF, no wrap.

Source files
------------

// File: rtl/fpga_rst_pkg.sv
// fpga_rst_pkg: shared state encoding, error counter width and sizing helper for the reset sequencer
package fpga_rst_pkg;
  typedef enum logic [2:0] {S_HOLD, S_DLY_RST, S_DLY_WAIT, S_RELEASE, S_DONE} rst_seq_state_t;
  localparam int ERR_CNT_W = 8;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/fpga_sync_bit.sv
// fpga_sync_bit: STAGES-deep single-bit synchronizer, asynchronously cleared to 0
module fpga_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic arst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  // shift the async input through the flop chain
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/fpga_rst_seq.sv
// fpga_rst_seq: PLL/IDELAYCTRL bring-up then staged domain reset release; define RST_SEQ_WDOG_EN for an RDY watchdog
module fpga_rst_seq
  import fpga_rst_pkg::*;
#(
  parameter int NUM_DOM     = 4,
  parameter int DLY_RST_CYC = 16,
  parameter int STEP_CYC    = 64,
  parameter int WDOG_CYC    = 4096,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 pll_lock,
  input  logic                 dly_rdy,
  output logic                 dly_rst,
  output logic [NUM_DOM-1:0]   rst_out,
  output logic                 seq_done,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam int CW = $clog2(max3(DLY_RST_CYC, STEP_CYC, WDOG_CYC) + 1);
  rst_seq_state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [NUM_DOM-1:0] rst_nxt;
  logic lock_s, rdy_s, bump;
  fpga_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (.clk(clk), .arst_n(arst_n), .d(pll_lock), .q(lock_s));
  fpga_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rdy (.clk(clk), .arst_n(arst_n), .d(dly_rdy), .q(rdy_s));
  // next state: lock loss beats RDY loss/watchdog, which beat normal progress; rst_out only ever shifts in zeros or reloads all ones
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    rst_nxt = rst_out;
    bump = 1'b0;
    if (state != S_HOLD && !lock_s) begin
      nxt = S_HOLD;
      cnt_nxt = '0;
      rst_nxt = '1;
    end else if ((state == S_RELEASE || state == S_DONE) && !rdy_s) begin
      nxt = S_DLY_RST;
      cnt_nxt = '0;
      rst_nxt = '1;
      bump = 1'b1;
    end else begin
      case (state)
        S_HOLD:
          if (lock_s) begin
            nxt = S_DLY_RST;
            cnt_nxt = '0;
          end
        S_DLY_RST:
          if (cnt == CW'(DLY_RST_CYC - 1)) begin
            nxt = S_DLY_WAIT;
            cnt_nxt = '0;
          end else cnt_nxt = cnt + CW'(1);
        S_DLY_WAIT:
          if (rdy_s) begin
            rst_nxt = rst_out << 1;
            cnt_nxt = '0;
            nxt = (rst_nxt == '0) ? S_DONE : S_RELEASE;
          end
`ifdef RST_SEQ_WDOG_EN
          else if (cnt == CW'(WDOG_CYC - 1)) begin
            nxt = S_DLY_RST;
            cnt_nxt = '0;
            bump = 1'b1;
          end else cnt_nxt = cnt + CW'(1);
`endif
        S_RELEASE:
          if (cnt == CW'(STEP_CYC - 1)) begin
            rst_nxt = rst_out << 1;
            cnt_nxt = '0;
            nxt = (rst_nxt == '0) ? S_DONE : S_RELEASE;
          end else cnt_nxt = cnt + CW'(1);
        default: ;
      endcase
    end
  end
  // register state and every output; err_cnt saturates instead of wrapping
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state <= S_HOLD;
      cnt <= '0;
      rst_out <= '1;
      dly_rst <= 1'b1;
      seq_done <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      rst_out <= rst_nxt;
      dly_rst <= (nxt == S_HOLD || nxt == S_DLY_RST);
      seq_done <= (state == S_DONE && nxt == S_DONE);
      err_cnt <= (bump && err_cnt != '1) ? err_cnt + ERR_CNT_W'(1) : err_cnt;
    end
endmodule
